// File: rtl/dma_pkg.sv
// Shared widths and encodings for the DMA storage datapath.
package dma_pkg;

  localparam int DATA_LEN        = 16;
  localparam int ADD_LEN         = 16;
  localparam int FIFO_DEPTH      = 5;
  localparam int FIFO_DIV_FACTOR = 3;

  // Encoding of the fifo_wr_rd select line.
  localparam logic WR = 1'b1;
  localparam logic RD = 1'b0;

endpackage

// File: rtl/dma_enreg.sv
// Generic register with asynchronous active-low reset, synchronous clear and load enable.
module dma_enreg
  import dma_pkg::*;
#(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Clear wins over load; otherwise hold.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      q <= '0;
    end else if (clr) begin
      q <= '0;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/dma_fifo.sv
// First-word fall-through FIFO with partial-empty flag and retry (previous pointer) access.
module dma_fifo
  import dma_pkg::*;
#(
  parameter int DATA       = DATA_LEN,
  parameter int ADDR_SIZE  = FIFO_DEPTH,
  parameter int DIV_FACTOR = FIFO_DIV_FACTOR
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            clr,
  input  logic            enable,
  input  logic            wr_rd,
  input  logic            old_add_flag,
  input  logic [DATA-1:0] din,
  output logic [DATA-1:0] dout,
  output logic            full,
  output logic            empty,
  output logic            empty_partial
);

  localparam int                    DEPTH    = 1 << ADDR_SIZE;
  localparam logic [ADDR_SIZE:0]    FULL_OCC = {1'b1, {ADDR_SIZE{1'b0}}};
  localparam logic [ADDR_SIZE:0]    PART_OCC = FULL_OCC >> DIV_FACTOR;
  localparam logic [ADDR_SIZE:0]    PTR_ONE  = {{ADDR_SIZE{1'b0}}, 1'b1};
  localparam logic [ADDR_SIZE-1:0]  ADDR_ONE = PTR_ONE[ADDR_SIZE-1:0];

  logic [DATA-1:0]      mem [DEPTH];
  logic [ADDR_SIZE:0]   wr_ptr;
  logic [ADDR_SIZE:0]   rd_ptr;
  logic [ADDR_SIZE:0]   occupancy;
  logic [ADDR_SIZE-1:0] wr_addr;
  logic [ADDR_SIZE-1:0] rd_addr;
  logic                 wr_do;
  logic                 rd_do;
  logic                 retry_wr_do;
  logic                 retry_rd_do;
  logic                 show_prev;

  // Extra pointer MSB distinguishes full from empty when the low bits match.
  assign occupancy     = wr_ptr - rd_ptr;
  assign full          = (occupancy == FULL_OCC);
  assign empty         = (occupancy == '0);
  assign empty_partial = (occupancy <= PART_OCC);

  // Clear overrides every access; normal accesses are dropped at the full/empty limits.
  assign wr_do       = !clr && enable && (wr_rd == WR) && !old_add_flag && !full;
  assign rd_do       = !clr && enable && (wr_rd == RD) && !old_add_flag && !empty;
  assign retry_wr_do = !clr && old_add_flag && (wr_rd == WR) && !empty;
  assign retry_rd_do = !clr && old_add_flag && (wr_rd == RD) && enable;

  // A retry write overwrites the most recently written word.
  assign wr_addr = retry_wr_do ? (wr_ptr[ADDR_SIZE-1:0] - ADDR_ONE) : wr_ptr[ADDR_SIZE-1:0];
  // After a retry read the output points back at the word consumed last.
  assign rd_addr = show_prev ? (rd_ptr[ADDR_SIZE-1:0] - ADDR_ONE) : rd_ptr[ADDR_SIZE-1:0];
  assign dout    = mem[rd_addr];

  dma_enreg #(.W(ADDR_SIZE + 1)) u_wr_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (wr_do),
    .d   (wr_ptr + PTR_ONE),
    .q   (wr_ptr)
  );

  dma_enreg #(.W(ADDR_SIZE + 1)) u_rd_ptr (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .en  (rd_do),
    .d   (rd_ptr + PTR_ONE),
    .q   (rd_ptr)
  );

  // Storage array; contents survive reset and clear.
  always_ff @(posedge clk) begin
    if (wr_do || retry_wr_do) begin
      mem[wr_addr] <= din;
    end
  end

  // Retry-read selector: set by a retry read, dropped by any other performed access.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      show_prev <= 1'b0;
    end else if (clr) begin
      show_prev <= 1'b0;
    end else if (retry_rd_do) begin
      show_prev <= 1'b1;
    end else if (wr_do || rd_do || retry_wr_do) begin
      show_prev <= 1'b0;
    end
  end

endmodule

// File: rtl/dma_buf_datapath.sv
// DMA storage datapath: FIFO, loadable offset counter and counter save register.
module dma_buf_datapath
  import dma_pkg::*;
#(
  parameter int DATA       = DATA_LEN,
  parameter int ADDR_SIZE  = FIFO_DEPTH,
  parameter int DIV_FACTOR = FIFO_DIV_FACTOR,
  parameter int CNT_W      = ADD_LEN - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             fifo_clr,
  input  logic             fifo_enable,
  input  logic             fifo_wr_rd,
  input  logic             fifo_old_add_flag,
  input  logic [DATA-1:0]  fifo_in,
  output logic [DATA-1:0]  fifo_out,
  output logic             full,
  output logic             empty,
  output logic             empty_partial,
  input  logic             cnt_clr,
  input  logic             cnt_en,
  input  logic             cnt_load,
  output logic [CNT_W-1:0] cnt,
  output logic             end_cnt,
  input  logic             save_clr,
  input  logic             save_en,
  output logic [CNT_W-1:0] saved
);

  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  dma_fifo #(
    .DATA       (DATA),
    .ADDR_SIZE  (ADDR_SIZE),
    .DIV_FACTOR (DIV_FACTOR)
  ) u_fifo (
    .clk           (clk),
    .rst           (rst),
    .clr           (fifo_clr),
    .enable        (fifo_enable),
    .wr_rd         (fifo_wr_rd),
    .old_add_flag  (fifo_old_add_flag),
    .din           (fifo_in),
    .dout          (fifo_out),
    .full          (full),
    .empty         (empty),
    .empty_partial (empty_partial)
  );

  dma_enreg #(.W(CNT_W)) u_save (
    .clk (clk),
    .rst (rst),
    .clr (save_clr),
    .en  (save_en),
    .d   (cnt),
    .q   (saved)
  );

  // Offset counter: clear, then restore from save register, then increment (wraps naturally).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= '0;
    end else if (cnt_clr) begin
      cnt <= '0;
    end else if (cnt_en) begin
      cnt <= cnt_load ? saved : (cnt + CNT_ONE);
    end
  end

  assign end_cnt = &cnt;

endmodule

// File: tb/tb_dma_buf_datapath.sv
// Scoreboard bench for dma_buf_datapath: reads push expected words, a negedge monitor pops and compares.
module tb_dma_buf_datapath;

  localparam int DATA       = 16;
  localparam int ADDR_SIZE  = 5;
  localparam int DIV_FACTOR = 3;
  localparam int CNT_W      = 15;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             fifo_clr = 1'b0;
  logic             fifo_enable = 1'b0;
  logic             fifo_wr_rd = 1'b0;
  logic             fifo_old_add_flag = 1'b0;
  logic [DATA-1:0]  fifo_in = '0;
  logic [DATA-1:0]  fifo_out;
  logic             full;
  logic             empty;
  logic             empty_partial;
  logic             cnt_clr = 1'b0;
  logic             cnt_en = 1'b0;
  logic             cnt_load = 1'b0;
  logic [CNT_W-1:0] cnt;
  logic             end_cnt;
  logic             save_clr = 1'b0;
  logic             save_en = 1'b0;
  logic [CNT_W-1:0] saved;

  int              n_vec = 0;
  int              n_err = 0;
  logic [DATA-1:0] exp_q[$];
  logic [DATA-1:0] mon_exp;

  dma_buf_datapath #(
    .DATA       (DATA),
    .ADDR_SIZE  (ADDR_SIZE),
    .DIV_FACTOR (DIV_FACTOR),
    .CNT_W      (CNT_W)
  ) dut (
    .clk               (clk),
    .rst               (rst),
    .fifo_clr          (fifo_clr),
    .fifo_enable       (fifo_enable),
    .fifo_wr_rd        (fifo_wr_rd),
    .fifo_old_add_flag (fifo_old_add_flag),
    .fifo_in           (fifo_in),
    .fifo_out          (fifo_out),
    .full              (full),
    .empty             (empty),
    .empty_partial     (empty_partial),
    .cnt_clr           (cnt_clr),
    .cnt_en            (cnt_en),
    .cnt_load          (cnt_load),
    .cnt               (cnt),
    .end_cnt           (end_cnt),
    .save_clr          (save_clr),
    .save_en           (save_en),
    .saved             (saved)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fifo_write(input logic [DATA-1:0] d);
    fifo_enable = 1'b1; fifo_wr_rd = 1'b1; fifo_old_add_flag = 1'b0; fifo_in = d;
    tick();
    fifo_enable = 1'b0;
  endtask

  task automatic fifo_read(input logic [DATA-1:0] e);
    exp_q.push_back(e);
    fifo_enable = 1'b1; fifo_wr_rd = 1'b0; fifo_old_add_flag = 1'b0;
    tick();
    fifo_enable = 1'b0;
  endtask

  task automatic retry_write(input logic [DATA-1:0] d);
    fifo_enable = 1'b0; fifo_wr_rd = 1'b1; fifo_old_add_flag = 1'b1; fifo_in = d;
    tick();
    fifo_old_add_flag = 1'b0; fifo_wr_rd = 1'b0;
  endtask

  task automatic retry_read();
    fifo_enable = 1'b1; fifo_wr_rd = 1'b0; fifo_old_add_flag = 1'b1;
    tick();
    fifo_enable = 1'b0; fifo_old_add_flag = 1'b0;
  endtask

  task automatic pulse_clr();
    fifo_clr = 1'b1;
    tick();
    fifo_clr = 1'b0;
  endtask

  // Monitor: every accepted read consumes the head word shown on fifo_out.
  always @(negedge clk) begin
    if (rst && fifo_enable && !fifo_wr_rd && !fifo_old_add_flag && !fifo_clr && !empty) begin
      n_vec++;
      if (exp_q.size() == 0) begin
        n_err++;
        $display("FAIL rd_unexpected: got 0x%04h with no word expected", fifo_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (fifo_out !== mon_exp) begin
          n_err++;
          $display("FAIL rd_data: got 0x%04h expected 0x%04h", fifo_out, mon_exp);
        end
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_empty", 32'(empty), 32'd1);
    check("rst_full", 32'(full), 32'd0);
    check("rst_ep", 32'(empty_partial), 32'd1);
    check("rst_cnt", 32'(cnt), 32'd0);
    check("rst_saved", 32'(saved), 32'd0);
    rst = 1'b1;
    tick();
    check("idle_empty", 32'(empty), 32'd1);
    check("idle_end_cnt", 32'(end_cnt), 32'd0);

    // Fill to full, then one ignored write
    for (int i = 0; i < 32; i++) begin
      fifo_write(16'(i));
      if (i == 30) check("full_at_31", 32'(full), 32'd0);
    end
    check("full_at_32", 32'(full), 32'd1);
    check("ep_at_32", 32'(empty_partial), 32'd0);
    fifo_write(16'hBEEF);
    check("full_after_33", 32'(full), 32'd1);
    check("head_after_fill", 32'(fifo_out), 32'h0000);

    // Drain in order with partial-empty threshold
    for (int i = 0; i < 32; i++) begin
      fifo_read(16'(i));
      if (i == 26) check("ep_occ5", 32'(empty_partial), 32'd0);
      if (i == 27) check("ep_occ4", 32'(empty_partial), 32'd1);
      if (i == 30) check("empty_occ1", 32'(empty), 32'd0);
    end
    check("empty_after_drain", 32'(empty), 32'd1);
    fifo_enable = 1'b1; fifo_wr_rd = 1'b0;
    tick();
    fifo_enable = 1'b0;
    check("extra_read_hold", 32'(fifo_out), 32'h0000);
    check("extra_read_empty", 32'(empty), 32'd1);

    // Refill across pointer wrap
    for (int i = 0; i < 24; i++) fifo_write(16'hA000 + 16'(i));
    for (int i = 0; i < 24; i++) fifo_read(16'hA000 + 16'(i));
    for (int i = 0; i < 16; i++) fifo_write(16'hB000 + 16'(i));
    check("wrap_ep", 32'(empty_partial), 32'd0);
    check("wrap_full", 32'(full), 32'd0);
    for (int i = 0; i < 16; i++) fifo_read(16'hB000 + 16'(i));
    check("wrap_empty", 32'(empty), 32'd1);

    // Clear, including clear racing a write
    for (int i = 0; i < 3; i++) fifo_write(16'hC000 + 16'(i));
    pulse_clr();
    check("clr_empty", 32'(empty), 32'd1);
    fifo_clr = 1'b1; fifo_enable = 1'b1; fifo_wr_rd = 1'b1; fifo_in = 16'hC0DE;
    tick();
    fifo_clr = 1'b0; fifo_enable = 1'b0;
    check("clr_beats_write", 32'(empty), 32'd1);

    // Retry write and retry read
    fifo_write(16'h1111);
    check("fwft_1111", 32'(fifo_out), 32'h1111);
    retry_write(16'h2222);
    check("retry_wr_data", 32'(fifo_out), 32'h2222);
    check("retry_wr_occ", 32'(empty), 32'd0);
    fifo_read(16'h2222);
    check("retry_wr_drained", 32'(empty), 32'd1);
    retry_write(16'h3333);
    retry_read();
    check("retry_wr_empty_ignored", 32'(fifo_out), 32'h2222);
    pulse_clr();
    fifo_write(16'hAAAA);
    fifo_write(16'hBBBB);
    fifo_read(16'hAAAA);
    check("head_bbbb", 32'(fifo_out), 32'hBBBB);
    retry_read();
    check("retry_rd_data", 32'(fifo_out), 32'hAAAA);
    check("retry_rd_ptrs", 32'(empty), 32'd0);
    pulse_clr();

    // Counter wrap
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    cnt_en = 1'b1;
    repeat (32766) tick();
    check("cnt_7ffe", 32'(cnt), 32'h7FFE);
    check("end_cnt_7ffe", 32'(end_cnt), 32'd0);
    tick();
    check("cnt_7fff", 32'(cnt), 32'h7FFF);
    check("end_cnt_7fff", 32'(end_cnt), 32'd1);
    tick();
    check("cnt_wrap", 32'(cnt), 32'h0000);
    check("end_cnt_wrap", 32'(end_cnt), 32'd0);
    cnt_en = 1'b0;

    // Save and restore
    cnt_clr = 1'b1; tick(); cnt_clr = 1'b0;
    cnt_en = 1'b1; repeat (9) tick(); cnt_en = 1'b0;
    check("cnt_9", 32'(cnt), 32'd9);
    save_en = 1'b1; tick(); save_en = 1'b0;
    check("saved_9", 32'(saved), 32'd9);
    cnt_en = 1'b1; repeat (11) tick(); cnt_en = 1'b0;
    check("cnt_20", 32'(cnt), 32'd20);
    cnt_load = 1'b1; tick();
    check("load_no_en", 32'(cnt), 32'd20);
    cnt_en = 1'b1; tick();
    check("load_restore", 32'(cnt), 32'd9);
    cnt_clr = 1'b1; tick();
    check("clr_beats_load", 32'(cnt), 32'd0);
    cnt_clr = 1'b0; cnt_en = 1'b0; cnt_load = 1'b0;
    save_clr = 1'b1; save_en = 1'b1; tick();
    save_clr = 1'b0; save_en = 1'b0;
    check("save_clr_beats_en", 32'(saved), 32'd0);

    // Reset asserted mid-traffic
    cnt_en = 1'b1; repeat (5) tick();
    save_en = 1'b1; tick(); save_en = 1'b0;
    fifo_write(16'h5555);
    fifo_write(16'h6666);
    fifo_enable = 1'b1; fifo_wr_rd = 1'b1; fifo_in = 16'hDEAD;
    #3;
    rst = 1'b0;
    #1;
    check("midrst_empty", 32'(empty), 32'd1);
    check("midrst_full", 32'(full), 32'd0);
    check("midrst_ep", 32'(empty_partial), 32'd1);
    check("midrst_cnt", 32'(cnt), 32'd0);
    check("midrst_saved", 32'(saved), 32'd0);
    fifo_enable = 1'b0; fifo_wr_rd = 1'b0; cnt_en = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    tick();
    check("postrst_empty", 32'(empty), 32'd1);
    check("postrst_cnt", 32'(cnt), 32'd0);
    check("postrst_saved", 32'(saved), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
